msrv32_div_unit: RTL and testbench

- Iterative radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU instructions.
- It is the multi-cycle counterpart of the single-cycle ALU: it consumes the same op_1/op_2 operand buses and returns a 32-bit result to the write-back mux.
- It uses a start/busy/valid handshake so the pipeline control can stall while the divide runs.

---
 rtl/msrv32_div_unit_if.sv | 25 ++
 rtl/msrv32_div_unit.sv | 172 +++++++++++++++++
 tb/tb_msrv32_div_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/msrv32_div_unit_if.sv
// rtl/msrv32_div_unit_if.sv - start/busy/valid handshake and operand bundle for the RV32M divider
interface msrv32_div_unit_if #(
   parameter int XLEN = 32
);
   logic            start_in;
   logic            flush_in;
   logic [XLEN-1:0] op_1_in;
   logic [XLEN-1:0] op_2_in;
   logic [1:0]      funct_in;
   logic            busy_out;
   logic            valid_out;
   logic [XLEN-1:0] result_out;

   // Pipeline control side: issues requests, observes completion
   modport master (
      output start_in, flush_in, op_1_in, op_2_in, funct_in,
      input  busy_out, valid_out, result_out
   );

   // Divider side
   modport slave (
      input  start_in, flush_in, op_1_in, op_2_in, funct_in,
      output busy_out, valid_out, result_out
   );
endinterface

// File: rtl/msrv32_div_unit.sv
// rtl/msrv32_div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU (optional MSRV32_DIV_EARLY_OUT_EN)
module msrv32_div_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic             ms_riscv32_mp_clk_in,
   input  logic             ms_riscv32_mp_rst_n_in,
   msrv32_div_unit_if.slave div_if
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [XLEN-1:0]   r_quo;
   logic [XLEN-1:0]   r_rem;
   logic [XLEN-1:0]   r_div;
   logic [XLEN-1:0]   r_dividend;
   logic [1:0]        r_funct;
   logic              r_q_neg;
   logic              r_r_neg;
   logic              r_div_zero;
   logic              r_busy;
   logic              r_valid;
   logic [XLEN-1:0]   r_result;

   logic              w_op1_neg;
   logic              w_op2_neg;
   logic              w_op2_zero;
   logic [XLEN-1:0]   w_abs1;
   logic [XLEN-1:0]   w_abs2;
   logic [XLEN:0]     w_shift;
   logic [XLEN:0]     w_trial;
   logic              w_fits;
   logic [XLEN-1:0]   w_next_rem;
   logic [XLEN-1:0]   w_next_quo;
   logic              w_last;
   logic [XLEN-1:0]   w_final;

   // Operand magnitudes: signed ops divide absolute values and fix signs at the end
   assign w_op1_neg  = ~div_if.funct_in[0] & div_if.op_1_in[XLEN-1];
   assign w_op2_neg  = ~div_if.funct_in[0] & div_if.op_2_in[XLEN-1];
   assign w_op2_zero = (div_if.op_2_in == '0);
   assign w_abs1     = w_op1_neg ? (~div_if.op_1_in + 1'b1) : div_if.op_1_in;
   assign w_abs2     = w_op2_neg ? (~div_if.op_2_in + 1'b1) : div_if.op_2_in;

   // One restoring step: partial remainder stays below the divisor, so an
   // XLEN+1 bit difference carries the sign of the trial in its top bit
   assign w_shift    = {r_rem, r_quo[XLEN-1]};
   assign w_trial    = w_shift - {1'b0, r_div};
   assign w_fits     = ~w_trial[XLEN];
   assign w_next_rem = w_fits ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
   assign w_next_quo = {r_quo[XLEN-2:0], w_fits};
   assign w_last     = (r_cnt == CNT_W'(XLEN-1));

   // Final result from the last iteration, with sign fix-up and divide-by-zero override
   always_comb begin
      w_final = '0;
      if (r_div_zero) begin
         w_final = r_funct[1] ? r_dividend : '1;
      end else if (r_funct[1]) begin
         w_final = r_r_neg ? (~w_next_rem + 1'b1) : w_next_rem;
      end else begin
         w_final = r_q_neg ? (~w_next_quo + 1'b1) : w_next_quo;
      end
   end

`ifdef MSRV32_DIV_EARLY_OUT_EN
   logic            w_ovf;
   logic            w_early;
   logic [XLEN-1:0] w_early_result;

   assign w_ovf   = ~div_if.funct_in[0]
                  & (div_if.op_1_in == {1'b1, {(XLEN-1){1'b0}}})
                  & (&div_if.op_2_in);
   assign w_early = w_op2_zero | w_ovf | (w_abs1 < w_abs2);

   // Results for operations that need no iterations at all
   always_comb begin
      w_early_result = '0;
      if (w_op2_zero) begin
         w_early_result = div_if.funct_in[1] ? div_if.op_1_in : '1;
      end else if (w_ovf) begin
         w_early_result = div_if.funct_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end else begin
         w_early_result = div_if.funct_in[1] ? div_if.op_1_in : '0;
      end
   end
`endif

   // Control FSM and datapath registers; all outputs are registered here
   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_quo      <= '0;
         r_rem      <= '0;
         r_div      <= '0;
         r_dividend <= '0;
         r_funct    <= '0;
         r_q_neg    <= 1'b0;
         r_r_neg    <= 1'b0;
         r_div_zero <= 1'b0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_result   <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (div_if.start_in && !div_if.flush_in) begin
                  r_quo      <= w_abs1;
                  r_rem      <= '0;
                  r_div      <= w_abs2;
                  r_dividend <= div_if.op_1_in;
                  r_funct    <= div_if.funct_in;
                  r_q_neg    <= w_op1_neg ^ w_op2_neg;
                  r_r_neg    <= w_op1_neg;
                  r_div_zero <= w_op2_zero;
                  r_cnt      <= '0;
`ifdef MSRV32_DIV_EARLY_OUT_EN
                  if (w_early) begin
                     r_state  <= S_DONE;
                     r_busy   <= 1'b0;
                     r_valid  <= 1'b1;
                     r_result <= w_early_result;
                  end else begin
                     r_state  <= S_CALC;
                     r_busy   <= 1'b1;
                  end
`else
                  r_state    <= S_CALC;
                  r_busy     <= 1'b1;
`endif
               end
            end
            S_CALC: begin
               if (div_if.flush_in) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_quo <= w_next_quo;
                  r_rem <= w_next_rem;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_last) begin
                     r_state  <= S_DONE;
                     r_busy   <= 1'b0;
                     r_valid  <= 1'b1;
                     r_result <= w_final;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign div_if.busy_out   = r_busy;
   assign div_if.valid_out  = r_valid;
   assign div_if.result_out = r_result;

endmodule

// File: tb/tb_msrv32_div_unit.sv
// tb/tb_msrv32_div_unit.sv - randomized and directed self-checking bench for msrv32_div_unit
module tb_msrv32_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] last_result;

   msrv32_div_unit_if #(.XLEN(32)) u_if ();

   msrv32_div_unit #(.XLEN(32), .CNT_W(6)) u_dut (
      .ms_riscv32_mp_clk_in   (clk),
      .ms_riscv32_mp_rst_n_in (rst_n),
      .div_if                 (u_if)
   );

   always #5 clk = ~clk;

   // Reference: RISC-V M-extension results from plain arithmetic
   function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = int'(a);
      sb = int'(b);
      if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
      case (f)
         2'b00: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
         2'b01: return a / b;
         2'b10: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
         default: return a % b;
      endcase
   endfunction

   // Reference latency in cycles from the accept edge to the valid cycle
   function automatic int exp_lat(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MSRV32_DIV_EARLY_OUT_EN
      longint ma;
      longint mb;
      ma = f[0] ? longint'(a) : longint'(int'(a));
      mb = f[0] ? longint'(b) : longint'(int'(b));
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (b == 32'd0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      if (ma < mb) return 1;
`endif
      return 33;
   endfunction

   // Issue one operation and measure it; operands are scrambled after accept
   task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic busy1, output logic busyv);
      @(negedge clk);
      u_if.start_in = 1'b1;
      u_if.funct_in = f;
      u_if.op_1_in  = a;
      u_if.op_2_in  = b;
      @(posedge clk);
      lat   = -1;
      res   = 32'hxxxx_xxxx;
      busy1 = 1'bx;
      busyv = 1'bx;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) begin
            busy1         = u_if.busy_out;
            u_if.start_in = 1'b0;
            u_if.op_1_in  = $urandom;
            u_if.op_2_in  = $urandom;
            u_if.funct_in = 2'($urandom);
         end
         if (u_if.valid_out) begin
            lat   = n;
            res   = u_if.result_out;
            busyv = u_if.busy_out;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      u_if.start_in = 1'b0;
      u_if.flush_in = 1'b0;
      u_if.op_1_in  = '0;
      u_if.op_2_in  = '0;
      u_if.funct_in = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (u_if.busy_out !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", u_if.busy_out); end
      n_cmp++; if (u_if.valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", u_if.valid_out); end
      n_cmp++; if (u_if.result_out !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h expected 00000000", u_if.result_out); end
      rst_n = 1'b1;
      @(negedge clk);
      last_result = 32'h0;
   endtask

   task automatic test_directed();
      logic [1:0]  t_f [0:9];
      logic [31:0] t_a [0:9];
      logic [31:0] t_b [0:9];
      logic [31:0] t_e [0:9];
      logic [31:0] res;
      int          lat;
      int          el;
      logic        b1;
      logic        bv;
      t_f = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10, 2'b01, 2'b10};
      t_a = '{32'hAABBCCDD, 32'hAABBCCDD, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h00000064,
              32'h00000064, 32'h80000000, 32'h80000000, 32'h00000064, 32'h00000064};
      t_b = '{32'h11223344, 32'h11223344, 32'h00000002, 32'h00000002, 32'h00000000,
              32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
      t_e = '{32'h00000009, 32'h1087FF79, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h00000064, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000064};
      for (int i = 0; i < 10; i++) begin
         el = exp_lat(t_f[i], t_a[i], t_b[i]);
         run_op(t_f[i], t_a[i], t_b[i], res, lat, b1, bv);
         n_cmp++; if (lat != el) begin n_bad++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, el); end
         n_cmp++; if (res !== t_e[i]) begin n_bad++; $display("FAIL dir%0d_result: got %h expected %h", i, res, t_e[i]); end
         n_cmp++; if (b1 !== (el != 1)) begin n_bad++; $display("FAIL dir%0d_busy_after_accept: got %b expected %b", i, b1, el != 1); end
         n_cmp++; if (bv !== 1'b0) begin n_bad++; $display("FAIL dir%0d_busy_at_valid: got %b expected 0", i, bv); end
         @(negedge clk);
         n_cmp++; if (u_if.valid_out !== 1'b0) begin n_bad++; $display("FAIL dir%0d_valid_pulse_width: got %b expected 0", i, u_if.valid_out); end
         n_cmp++; if (u_if.result_out !== t_e[i]) begin n_bad++; $display("FAIL dir%0d_result_hold: got %h expected %h", i, u_if.result_out, t_e[i]); end
         last_result = t_e[i];
      end
   endtask

   task automatic test_flush();
      logic [31:0] res;
      int          lat;
      int          seen;
      logic        b1;
      logic        bv;
      // start and flush together in IDLE: nothing accepted
      @(negedge clk);
      u_if.start_in = 1'b1; u_if.flush_in = 1'b1;
      u_if.funct_in = 2'b01; u_if.op_1_in = 32'd100; u_if.op_2_in = 32'd7;
      @(negedge clk);
      u_if.start_in = 1'b0; u_if.flush_in = 1'b0;
      n_cmp++; if (u_if.busy_out !== 1'b0) begin n_bad++; $display("FAIL flush_start_idle_busy: got %b expected 0", u_if.busy_out); end
      // flush at cycle 10 of DIVU 100/7
      u_if.start_in = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (n == 1) u_if.start_in = 1'b0;
         if (n == 10) u_if.flush_in = 1'b1;
      end
      n_cmp++; if (u_if.busy_out !== 1'b1) begin n_bad++; $display("FAIL flush_busy_before: got %b expected 1", u_if.busy_out); end
      @(negedge clk);
      u_if.flush_in = 1'b0;
      n_cmp++; if (u_if.busy_out !== 1'b0) begin n_bad++; $display("FAIL flush_busy_after: got %b expected 0", u_if.busy_out); end
      seen = 0;
      for (int n = 0; n < 40; n++) begin
         if (u_if.valid_out) seen++;
         @(negedge clk);
      end
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL flush_no_valid: got %0d pulses expected 0", seen); end
      n_cmp++; if (u_if.result_out !== last_result) begin n_bad++; $display("FAIL flush_result_kept: got %h expected %h", u_if.result_out, last_result); end
      run_op(2'b01, 32'd100, 32'd7, res, lat, b1, bv);
      n_cmp++; if (res !== 32'd14) begin n_bad++; $display("FAIL flush_restart_result: got %h expected %h", res, 32'd14); end
      n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL flush_restart_latency: got %0d expected 33", lat); end
      last_result = 32'd14;
   endtask

   task automatic test_reset_mid_op();
      int seen;
      @(negedge clk);
      u_if.start_in = 1'b1; u_if.funct_in = 2'b01;
      u_if.op_1_in = 32'hFFFF_FFFF; u_if.op_2_in = 32'd3;
      @(posedge clk);
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         if (n == 1) u_if.start_in = 1'b0;
      end
      n_cmp++; if (u_if.busy_out !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy_before: got %b expected 1", u_if.busy_out); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (u_if.busy_out !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b expected 0", u_if.busy_out); end
      n_cmp++; if (u_if.valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b expected 0", u_if.valid_out); end
      n_cmp++; if (u_if.result_out !== 32'h0) begin n_bad++; $display("FAIL rst_mid_result: got %h expected 00000000", u_if.result_out); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (u_if.valid_out) seen++;
      end
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_mid_no_valid: got %0d pulses expected 0", seen); end
      last_result = 32'h0;
   endtask

   task automatic test_start_held();
      int          pos [$];
      logic [31:0] vals [$];
      logic        busy34;
      logic        busy35;
      @(negedge clk);
      u_if.start_in = 1'b1; u_if.funct_in = 2'b01;
      u_if.op_1_in = 32'd1000; u_if.op_2_in = 32'd7;
      @(posedge clk);
      busy34 = 1'bx;
      busy35 = 1'bx;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (u_if.valid_out) begin pos.push_back(n); vals.push_back(u_if.result_out); end
         if (n == 34) busy34 = u_if.busy_out;
         if (n == 35) busy35 = u_if.busy_out;
      end
      u_if.start_in = 1'b0;
      n_cmp++; if (pos.size() != 2) begin n_bad++; $display("FAIL held_pulse_count: got %0d expected 2", pos.size()); end
      if (pos.size() >= 2) begin
         n_cmp++; if (pos[0] != 33) begin n_bad++; $display("FAIL held_first_pos: got %0d expected 33", pos[0]); end
         n_cmp++; if (pos[1] != 67) begin n_bad++; $display("FAIL held_second_pos: got %0d expected 67", pos[1]); end
         n_cmp++; if (vals[1] !== 32'd142) begin n_bad++; $display("FAIL held_second_result: got %h expected %h", vals[1], 32'd142); end
      end
      n_cmp++; if (busy34 !== 1'b0) begin n_bad++; $display("FAIL held_idle_gap_busy: got %b expected 0", busy34); end
      n_cmp++; if (busy35 !== 1'b1) begin n_bad++; $display("FAIL held_reaccept_busy: got %b expected 1", busy35); end
      repeat (45) @(negedge clk);
      last_result = 32'd142;
   endtask

   task automatic test_random();
      logic [1:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [31:0] er;
      int          lat;
      int          el;
      logic        b1;
      logic        bv;
      for (int i = 0; i < 40; i++) begin
         f = 2'($urandom);
         a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 15));
            3: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         er = ref_result(f, a, b);
         el = exp_lat(f, a, b);
         run_op(f, a, b, res, lat, b1, bv);
         n_cmp++; if (res !== er) begin n_bad++; $display("FAIL rnd%0d_result f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, er); end
         n_cmp++; if (lat != el) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, el); end
         n_cmp++; if (bv !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_busy_at_valid: got %b expected 0", i, bv); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_flush();
      test_reset_mid_op();
      test_start_held();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
